// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, error pulses and a FWFT output FIFO
module uart_rx #(
    parameter int CLOCK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE     = 115200,
    parameter int DEPTH         = 4
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       RXD,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV  = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          rx_meta, rxs;
    logic          push_req, ferr_n;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wp, rp;
    logic          full, pop, push, ovr_n;

    // two-flop synchronizer; idle-high so reset does not look like a start bit
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rxs     <= rx_meta;
        end
    end

    // receiver state registers
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
        end
    end

    // next-state: one down-counter times every sample point of the frame
    always_comb begin
        state_n  = state;
        cnt_n    = cnt - CW'(1);
        idx_n    = idx;
        sh_n     = sh;
        push_req = 1'b0;
        ferr_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = cnt;
                if (!rxs) begin
                    state_n = START;
                    cnt_n   = HALF_M1;
                end
            end
            START: if (cnt == '0) begin
                cnt_n   = DIV_M1;
                idx_n   = '0;
                state_n = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == '0) begin
                sh_n  = {rxs, sh[7:1]};
                cnt_n = DIV_M1;
                idx_n = idx + 3'd1;
                if (idx == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == '0) begin
                state_n  = rxs ? IDLE : BRK;
                push_req = rxs;
                ferr_n   = !rxs;
            end
            BRK: begin
                cnt_n = cnt;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign valid = wp != rp;
    assign pop   = valid && ready;
    assign push  = push_req && (!full || pop);
    assign ovr_n = push_req && full && !pop;
    assign data  = mem[rp[AW-1:0]];
    assign busy  = state != IDLE;

    // FIFO storage, pointers and registered error pulses
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp        <= '0;
            rp        <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) begin
                mem[wp[AW-1:0]] <= sh;
                wp <= wp + (AW+1)'(1);
            end
            if (pop) rp <= rp + (AW+1)'(1);
            frame_err <= ferr_n;
            overrun   <= ovr_n;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx
module tb_uart_rx;
    localparam int DIV = 104;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       RXD = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         ferr_cnt = 0, ovr_cnt = 0, vcyc = 0, vrise = 0;
    logic       vprev = 1'b0;
    logic [7:0] got [$];

    uart_rx dut (
        .clk(clk), .resetq(resetq), .RXD(RXD), .data(data), .valid(valid),
        .ready(ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // observe outputs mid-cycle; inputs only change 2 time units after a rising edge
    always @(negedge clk) begin
        if (resetq) begin
            if (valid && ready) got.push_back(data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (valid) vcyc++;
            if (valid && !vprev) vrise = cyc;
        end
        vprev = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bit_for(input logic v, input int n);
        RXD = v;
        repeat (n * DIV) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        t0 = cyc;
        bit_for(1'b0, 1);
        for (int i = 0; i < 8; i++) bit_for(b[i], 1);
        bit_for(stop, 1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_valid", 32'(valid), 0);
        check("rst_data", 32'(data), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        resetq = 1'b1;
        ready = 1'b1;
        bit_for(1'b1, 10);

        vcyc = 0;
        send_frame(8'h61, 1'b1);
        repeat (5) tick();
        check("t1_count", 32'(got.size()), 1);
        check("t1_byte", 32'(got[0]), 32'h61);
        check("t1_vcycles", 32'(vcyc), 1);
        check("t1_latency", 32'(vrise - t0), 991);
        check("t1_ferr", 32'(ferr_cnt), 0);
        check("t1_ovr", 32'(ovr_cnt), 0);
        check("t1_busy", 32'(busy), 0);

        got.delete();
        vcyc = 0;
        RXD = 1'b0;
        repeat (20) tick();
        RXD = 1'b1;
        repeat (5) tick();
        check("t2_busy_mid", 32'(busy), 1);
        repeat (60) tick();
        check("t2_busy_end", 32'(busy), 0);
        check("t2_valid", 32'(vcyc), 0);
        check("t2_ferr", 32'(ferr_cnt), 0);

        bit_for(1'b1, 2);
        bit_for(1'b0, 1);
        for (int i = 0; i < 8; i++) bit_for(1'(8'h55 >> i), 1);
        bit_for(1'b0, 3);
        check("t3_busy_break", 32'(busy), 1);
        bit_for(1'b1, 1);
        send_frame(8'hA3, 1'b1);
        bit_for(1'b1, 1);
        check("t3_ferr", 32'(ferr_cnt), 1);
        check("t3_count", 32'(got.size()), 1);
        check("t3_byte", 32'(got[0]), 32'hA3);

        got.delete();
        ready = 1'b0;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        bit_for(1'b1, 1);
        check("t4_ovr", 32'(ovr_cnt), 1);
        check("t4_valid", 32'(valid), 1);
        check("t4_head", 32'(data), 32'h01);
        ready = 1'b1;
        repeat (6) tick();
        check("t4_drained", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++) check("t4_order", 32'(got[i]), 32'(i + 1));
        check("t4_empty", 32'(valid), 0);

        got.delete();
        ready = 1'b0;
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
        bit_for(1'b1, 1);
        fork
            send_frame(8'h05, 1'b1);
            begin
                repeat (990) tick();
                ready = 1'b1;
                tick();
                ready = 1'b0;
            end
        join
        bit_for(1'b1, 1);
        check("t5_ovr", 32'(ovr_cnt), 1);
        check("t5_popped", 32'(got.size()), 1);
        check("t5_pop_byte", 32'(got[0]), 32'h01);
        check("t5_head", 32'(data), 32'h02);
        ready = 1'b1;
        repeat (6) tick();
        check("t5_count", 32'(got.size()), 5);
        check("t5_last", 32'(got[4]), 32'h05);

        got.delete();
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("t6_queued", 32'(valid), 1);
        bit_for(1'b0, 1);
        for (int i = 0; i < 4; i++) bit_for(1'(8'h33 >> i), 1);
        RXD = 1'b1;
        repeat (50) tick();
        check("t6_busy_pre", 32'(busy), 1);
        resetq = 1'b0;
        #3;
        check("t6_valid", 32'(valid), 0);
        check("t6_data", 32'(data), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_ferr", 32'(frame_err), 0);
        check("t6_ovr", 32'(overrun), 0);
        repeat (4) tick();
        resetq = 1'b1;
        ready = 1'b1;
        bit_for(1'b1, 2);
        check("t6_idle", 32'(busy), 0);
        send_frame(8'h7E, 1'b1);
        bit_for(1'b1, 1);
        check("t6_count", 32'(got.size()), 1);
        check("t6_byte", 32'(got[0]), 32'h7E);
        check("t6_ferr_total", 32'(ferr_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end inside `top`. Consumes the asynchronous `RXD` line at 115200 baud 8N1 from a 12 MHz clock, samples each bit at mid-bit, and delivers received bytes to the command/echo logic through a small first-word-fall-through FIFO with a valid/ready handshake. It also flags framing errors and FIFO overruns so downstream logic can count or report them.

## Interface
- `CLOCK_FREQ_HZ`, 12000000: system clock frequency.
- `BAUD_RATE`, 115200: line rate.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- Derived: `DIV` = `CLOCK_FREQ_HZ/BAUD_RATE` (integer truncation, 104 at defaults); `HALF` = `DIV/2` (52).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `resetq`  in  1  asynchronous, active-low reset.
- `RXD`  in  1  serial input, idle high, asynchronous to `clk`.
- `data`  out  8  FIFO head byte.
- `valid`  out  1  FIFO non-empty.
- `ready`  in  1  consumer accepts head when `valid && ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because FIFO full.
- `busy`  out  1  receiver FSM not in IDLE.

## Operation
- `RXD` passes through a 2-flop synchronizer; both flops reset to 1. All FSM decisions use the synchronized value `rxs`.
- A single down-counter `cnt` (width ≥ clog2(`DIV`)) times the samples. Bit index 0..7. Shift register fills LSB first.
- FSM states:
  - IDLE: when `rxs`=0, load `cnt`=`HALF`-1 and go to START.
  - START: decrement. At `cnt`=0, sample `rxs`. If 0, load `DIV`-1, set index 0, go to DATA. If 1 (glitch), go to IDLE with no outputs.
  - DATA: decrement. At `cnt`=0, shift in `rxs` and reload `DIV`-1. After bit index 7, go to STOP.
  - STOP: at `cnt`=0, sample `rxs`. If 1, push the byte and go to IDLE. If 0, pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: stay until `rxs`=1, then go to IDLE. Line held low pulses `frame_err` only once.
- FIFO: `DEPTH` entries, read/write pointers one bit wider than the address; `valid` = pointers differ.
  - `data` shows the head entry combinationally from registered storage.
  - Pop on `valid && ready`.
- Push when full: if a pop happens in the same cycle, the push is accepted and the count is unchanged. Otherwise the byte is dropped, `overrun` pulses, and existing contents are kept.
- A pop while empty is ignored. `ready` is ignored when `valid`=0.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: state IDLE, FIFO empty, `valid`=0, `data`=8'h00, `frame_err`=0, `overrun`=0, `busy`=0. Storage resets to 0.
- Assertion of `resetq` mid-frame aborts immediately. The partial byte is lost and FIFO contents are cleared. After release, the receiver waits for a fresh falling edge.
- Cycle t is the first cycle the FSM sees `rxs`=0 in IDLE (2–3 cycles after the line edge).
  - Start sample at t+`HALF`.
  - Data bit k (0..7) sampled at t+`HALF`+(k+1)·`DIV`.
  - Stop sample at t+`HALF`+9·`DIV` (t+988 at defaults).
- The push at the stop-sample edge makes `valid`=1 and `data` = byte in the following cycle.
- `frame_err` and `overrun` are asserted exactly one cycle, in the cycle after the stop sample.
- The FSM returns to IDLE in the cycle after the stop sample. A start bit immediately following the stop bit (stop length 1 bit) is captured. Back-to-back frames are received without loss.
- `valid`/`data` change only on push to an empty FIFO or on pop. Head is stable while `valid && !ready`.

## Test plan
- Send 0x61 at 115200 after 10 idle bit times, `ready`=1 → `valid` pulses one cycle with `data`=0x61, no error pulses, `busy` low afterwards.
- 20-cycle low glitch on `RXD` → FSM returns to IDLE at the start sample; no `valid`, no `frame_err`.
- Frame 0x55 with stop bit driven 0 for 3 bit times, then high, then a valid 0xA3 → exactly one `frame_err` pulse, 0x55 never appears, then `data`=0xA3 valid.
- `ready`=0, send 0x01..0x05 back-to-back → 4 entries held, one `overrun` after the 5th stop bit; then `ready`=1 drains 0x01,0x02,0x03,0x04 in order and `valid`=0.
- FIFO full with `ready` asserted for one cycle exactly at a push → no `overrun`, 0x01 popped, new byte stored as 4th entry.
- Pull `resetq` low during data bit 4 with 2 bytes queued → all outputs at reset values; after release, next frame 0x7E received correctly.
